state_dump_unit: RTL and testbench
==================================

Name: state_dump_unit

Overview:
- Hardware end-of-run observer for the single-cycle MIPS `machine`.
- Watches the fetched instruction and a cycle budget. On halt, it freezes the machine and reads out architectural state as a valid/ready word stream: PC, then all 32 registers, then the data-memory bytes at MEM_BASE.
- It is the reading side of the state that bench stimulus and preloads write into the machine.
- It sits beside `machine`; its stream feeds the trace UART/FIFO.

Parameters:
- NUM_REGS, 32, register-file entries dumped (indices 0..NUM_REGS-1).
- MEM_BASE, 32'h00004000, first data-memory byte address dumped.
- MEM_BYTES, 4, number of consecutive data-memory bytes dumped.
- TIMEOUT_CYCLES, 64, run-cycle budget before a forced halt.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- inst  in  32  machine's current fetched instruction.
- pc  in  32  machine's byte PC ({PC_reg.q, 2'b00}).
- freeze  out  1  stalls machine state updates (PC, register file, memory writes).
- rf_raddr  out  5  register-file read index (combinational read).
- rf_rdata  in  32  register-file read data.
- mem_raddr  out  32  data-memory byte read address.
- mem_rdata  in  8  data-memory read byte (combinational).
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer ready.
- out_data  out  32  stream word.
- out_kind  out  2  word type: 0 = PC, 1 = register, 2 = memory byte.
- halt_cause  out  1  0 = zero instruction, 1 = timeout.
- dump_done  out  1  dump complete, sticky.

Behaviour:
- Reset values (any cycle with reset=1):
  - state RUN, cycle counter 0, index 0.
  - freeze=0, out_valid=0, out_data=0, out_kind=0, halt_cause=0, dump_done=0.
  - rf_raddr=0, mem_raddr=MEM_BASE.
- States:
  - RUN → DUMP_PC → DUMP_REG → DUMP_MEM → DONE.
- RUN:
  - Counter increments every cycle.
  - Halt is detected at a rising edge when inst==32'h0 or counter==TIMEOUT_CYCLES-1.
  - Only an exact zero instruction counts; X/Z never halts.
  - If both conditions hold in the same cycle, halt_cause=0 (the instruction wins).
  - On halt: go to DUMP_PC, set freeze=1 from the next cycle onward, latch halt_cause.
- freeze stays 1 in every state except RUN, so rf_rdata, mem_rdata and pc are stable throughout the dump.
- DUMP_PC:
  - out_valid=1, out_kind=0, out_data=pc.
  - On out_valid&&out_ready: go to DUMP_REG with index 0.
- DUMP_REG:
  - rf_raddr=index[4:0], out_data=rf_rdata, out_kind=1, out_valid=1.
  - Each handshake increments index.
  - On handshake at index NUM_REGS-1: go to DUMP_MEM, index←0.
- DUMP_MEM:
  - mem_raddr=MEM_BASE+index, out_data={24'b0, mem_rdata}, out_kind=2, out_valid=1.
  - On handshake at index MEM_BYTES-1: go to DONE.
- DONE:
  - out_valid=0, dump_done=1, freeze=1; held until reset.
- Handshake rules:
  - A word transfers on the cycle out_valid&&out_ready.
  - out_data/out_kind are stable while out_valid=1 and out_ready=0.
  - Once out_valid is asserted it is never withdrawn without a transfer.
  - Back-to-back transfers run at 1 word/cycle.
- Latency:
  - First word is valid the cycle after the halt edge.
  - Full dump takes 1+NUM_REGS+MEM_BYTES transfers (37 by default).
- Counter is sized to clog2(TIMEOUT_CYCLES)+1 bits and does not wrap: the timeout fires before wrap.
- Reset mid-dump aborts immediately. The next cycle is RUN with freeze=0 and no partial word left valid.
- Index is compared at its full width. The unit is sized so NUM_REGS ≤ 32; elaboration must fail if NUM_REGS > 32.

Decomposition:
- Shared package `dump_pkg`:
  - out_kind constants KIND_PC/KIND_REG/KIND_MEM.
  - State enum encoding.
  - HALT_INST=32'h0.
  - Halt-cause constants.
- One sub-module is natural: `halt_detector` (cycle counter + zero-instruction compare → halt pulse, cause).
- The main module holds the dump FSM and read sequencing.

Test Plan:
- Zero instruction at cycle 5, out_ready=1, r2=r3=0x00400008 → halt_cause=0, freeze high from cycle 6. Stream is PC, then 32 registers with words 3 and 4 = 0x00400008, then 4 memory bytes, 37 transfers back-to-back. dump_done=1 after the last.
- Non-zero instructions forever, TIMEOUT_CYCLES=64 → halt on cycle 63 with halt_cause=1, first word out_kind=0.
- inst==0 on exactly cycle 63 → halt_cause=0.
- out_ready toggled 1/0 every cycle plus random stalls → out_data/out_kind held during stalls, no words duplicated or skipped, order PC, r0..r31, mem[0x4000..0x4003].
- mem[0x4002]=8'hA5 → the third memory word is 0x000000A5 with out_kind=2.
- Reset asserted mid-DUMP_REG at index 10 → next cycle state RUN, freeze=0, out_valid=0, dump_done=0. A subsequent halt restarts the dump from PC.

Source files
------------

// File: rtl/state_dump_unit_pkg.sv
// Shared definitions for the end-of-run state dump: stream word kinds,
// dump FSM encoding and halt-cause codes.
package dump_pkg;

   localparam int KIND_W = 2;

   localparam logic [KIND_W-1:0] KIND_PC  = 2'd0;
   localparam logic [KIND_W-1:0] KIND_REG = 2'd1;
   localparam logic [KIND_W-1:0] KIND_MEM = 2'd2;

   localparam logic [31:0] HALT_INST = 32'h0000_0000;

   localparam logic CAUSE_ZERO_INST = 1'b0;
   localparam logic CAUSE_TIMEOUT   = 1'b1;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_DUMP_PC  = 3'd1,
      ST_DUMP_REG = 3'd2,
      ST_DUMP_MEM = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   function automatic logic [31:0] zext_byte(input logic [7:0] b);
      return {24'b0, b};
   endfunction

endpackage

// File: rtl/state_dump_unit_if.sv
// Valid/ready word stream carrying the dumped architectural state.
interface state_dump_unit_if;
   import dump_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic [KIND_W-1:0] out_kind;

   modport master (output out_valid, output out_data, output out_kind, input out_ready);
   modport slave  (input out_valid, input out_data, input out_kind, output out_ready);

endinterface

// File: rtl/state_dump_unit_halt_detector.sv
// Run-cycle budget counter plus zero-instruction compare; raises a halt
// request with its cause while the machine is running.
module halt_detector
   import dump_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run_i,
   input  logic [31:0] inst_i,
   output logic        halt_o,
   output logic        cause_o
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             zero_inst;
   logic             budget_out;

   always_comb begin
      zero_inst = 1'b0;
      // An unknown instruction leaves the if-condition false, so X/Z never halts.
      if (inst_i == HALT_INST) begin
         zero_inst = 1'b1;
      end
      budget_out = (cnt_q == CNT_LAST);
      halt_o     = run_i && (zero_inst || budget_out);
      cause_o    = CAUSE_TIMEOUT;
      if (zero_inst) begin
         cause_o = CAUSE_ZERO_INST;
      end
      cnt_d = cnt_q;
      if (run_i && !budget_out) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/state_dump_unit.sv
// End-of-run observer for the single-cycle machine: on halt it freezes the
// core and streams PC, the register file and a window of data memory.
module state_dump_unit
   import dump_pkg::*;
#(
   parameter int          NUM_REGS       = 32,
   parameter logic [31:0] MEM_BASE       = 32'h0000_4000,
   parameter int          MEM_BYTES      = 4,
   parameter int          TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        inst,
   input  logic [31:0]        pc,
   output logic               freeze,
   output logic [4:0]         rf_raddr,
   input  logic [31:0]        rf_rdata,
   output logic [31:0]        mem_raddr,
   input  logic [7:0]         mem_rdata,
   state_dump_unit_if.master  out_if,
   output logic               halt_cause,
   output logic               dump_done
);

   localparam int               IDX_MAX  = (NUM_REGS > MEM_BYTES) ? NUM_REGS : MEM_BYTES;
   localparam int               IDX_W    = $clog2(IDX_MAX) + 1;
   localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_BYTES - 1);

   if (NUM_REGS > 32) begin : g_num_regs_check
      $error("state_dump_unit: NUM_REGS must not exceed 32");
   end

   state_e           state_q;
   state_e           state_d;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic             cause_q;
   logic             cause_d;
   logic             run;
   logic             halt;
   logic             halt_cause_now;

   assign run = (state_q == ST_RUN) && !reset;

   halt_detector #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_halt_detector (
      .clk     (clk),
      .reset   (reset),
      .run_i   (run),
      .inst_i  (inst),
      .halt_o  (halt),
      .cause_o (halt_cause_now)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         idx_q   <= '0;
         cause_q <= CAUSE_ZERO_INST;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cause_q <= cause_d;
      end
   end

   // Outputs are forced to their reset values whenever reset is high, so an
   // aborted dump never presents a partial word in the reset cycle itself.
   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      cause_d          = cause_q;
      freeze           = 1'b0;
      rf_raddr         = '0;
      mem_raddr        = MEM_BASE;
      out_if.out_valid = 1'b0;
      out_if.out_data  = '0;
      out_if.out_kind  = KIND_PC;
      halt_cause       = CAUSE_ZERO_INST;
      dump_done        = 1'b0;

      if (!reset) begin
         freeze     = (state_q != ST_RUN);
         halt_cause = cause_q;
         unique case (state_q)
            ST_RUN: begin
               if (halt) begin
                  state_d = ST_DUMP_PC;
                  cause_d = halt_cause_now;
               end
            end
            ST_DUMP_PC: begin
               out_if.out_valid = 1'b1;
               out_if.out_kind  = KIND_PC;
               out_if.out_data  = pc;
               if (out_if.out_ready) begin
                  state_d = ST_DUMP_REG;
                  idx_d   = '0;
               end
            end
            ST_DUMP_REG: begin
               rf_raddr         = 5'(idx_q);
               out_if.out_valid = 1'b1;
               out_if.out_kind  = KIND_REG;
               out_if.out_data  = rf_rdata;
               if (out_if.out_ready) begin
                  if (idx_q == REG_LAST) begin
                     state_d = ST_DUMP_MEM;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            ST_DUMP_MEM: begin
               mem_raddr        = MEM_BASE + 32'(idx_q);
               out_if.out_valid = 1'b1;
               out_if.out_kind  = KIND_MEM;
               out_if.out_data  = zext_byte(mem_rdata);
               if (out_if.out_ready) begin
                  if (idx_q == MEM_LAST) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               dump_done = 1'b1;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: a small machine model supplies PC, registers and
// memory; the expected stream is the machine snapshot taken when it halts.
module tb_state_dump_unit;
   import dump_pkg::*;

   localparam int NREG  = 32;
   localparam int NMEM  = 4;
   localparam int TOTAL = 1 + NREG + NMEM;
   localparam int TMO   = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inst = 32'h1;
   logic [31:0] pc = 32'h0;
   logic        freeze;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic [31:0] mem_raddr;
   logic [7:0]  mem_rdata;
   logic        halt_cause;
   logic        dump_done;

   logic [31:0] regs_m [NREG];
   logic [7:0]  mem_m  [NMEM];
   logic [31:0] mem_off;

   int n_cmp = 0;
   int n_bad = 0;
   int cur_case = 0;

   always #5 clk = ~clk;

   state_dump_unit_if sif ();

   state_dump_unit #(
      .NUM_REGS       (NREG),
      .MEM_BASE       (32'h0000_4000),
      .MEM_BYTES      (NMEM),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .inst       (inst),
      .pc         (pc),
      .freeze     (freeze),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .out_if     (sif.master),
      .halt_cause (halt_cause),
      .dump_done  (dump_done)
   );

   // Combinational register-file and data-memory read ports of the machine.
   always_comb begin
      rf_rdata  = regs_m[rf_raddr];
      mem_off   = mem_raddr - 32'h0000_4000;
      mem_rdata = 8'h00;
      if (mem_off < 32'(NMEM)) begin
         mem_rdata = mem_m[mem_off[1:0]];
      end
   end

   typedef struct {
      int zero_at;
      int mode;
      int abort_at;
      bit start_reset;
      bit a5;
      int exp_h;
      bit exp_cause;
   } vec_t;

   vec_t tbl [7];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL case%0d %s: got %h expected %h", cur_case, nm, act, exp);
      end
   endfunction

   function automatic logic [1:0] kind_of(input int w);
      if (w == 0) return KIND_PC;
      if (w <= NREG) return KIND_REG;
      return KIND_MEM;
   endfunction

   task automatic run_case(input int zero_at, input int mode, input int abort_at,
                           input bit start_reset, input bit a5, input int exp_h,
                           input bit exp_cause);
      logic [31:0] exp_w [TOTAL];
      int c;
      int widx;
      int tail;
      bit fin;
      bit frz_prev;

      pc = 32'h0040_0000;
      for (int i = 0; i < NREG; i++) regs_m[i] = (i == 0) ? 32'h0 : $urandom;
      regs_m[2] = 32'h0040_0008;
      regs_m[3] = 32'h0040_0008;
      for (int j = 0; j < NMEM; j++) mem_m[j] = 8'($urandom);
      if (a5) mem_m[2] = 8'hA5;
      for (int k = 0; k < TOTAL; k++) exp_w[k] = 32'h0;

      if (start_reset) begin
         @(negedge clk);
         reset = 1'b1;
         inst = 32'h1;
         sif.out_ready = 1'b1;
         @(negedge clk);
         #1;
         chk("rst_freeze", 32'(freeze), 32'd0);
         chk("rst_valid", 32'(sif.out_valid), 32'd0);
         chk("rst_data", sif.out_data, 32'd0);
         chk("rst_kind", 32'(sif.out_kind), 32'd0);
         chk("rst_cause", 32'(halt_cause), 32'd0);
         chk("rst_done", 32'(dump_done), 32'd0);
         chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
         chk("rst_mem_raddr", mem_raddr, 32'h0000_4000);
         reset = 1'b0;
      end

      c = 0; widx = 0; tail = 0; fin = 1'b0; frz_prev = 1'b0;
      while (!fin) begin
         if (c > 0) begin
            @(negedge clk);
            if (!frz_prev) begin
               pc = pc + 32'd4;
               regs_m[31] = pc;
            end
         end
         inst = (c == zero_at) ? HALT_INST : ($urandom | 32'h1);
         case (mode)
            0:       sif.out_ready = 1'b1;
            1:       sif.out_ready = (c % 2 == 0);
            default: sif.out_ready = (c % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
         endcase
         if (c == exp_h + 1) begin
            exp_w[0] = pc;
            for (int i = 0; i < NREG; i++) exp_w[1 + i] = regs_m[i];
            for (int j = 0; j < NMEM; j++) exp_w[1 + NREG + j] = {24'h0, mem_m[j]};
         end
         if (abort_at >= 0 && c > exp_h && widx == abort_at) begin
            reset = 1'b1;
            #1;
            chk("abort_rst_valid", 32'(sif.out_valid), 32'd0);
            chk("abort_rst_freeze", 32'(freeze), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk("abort_freeze", 32'(freeze), 32'd0);
            chk("abort_valid", 32'(sif.out_valid), 32'd0);
            chk("abort_done", 32'(dump_done), 32'd0);
            chk("abort_cause", 32'(halt_cause), 32'd0);
            return;
         end
         #1;
         frz_prev = freeze;
         if (c <= exp_h) begin
            chk("run_freeze", 32'(freeze), 32'd0);
            chk("run_valid", 32'(sif.out_valid), 32'd0);
            chk("run_done", 32'(dump_done), 32'd0);
         end else begin
            chk("dump_freeze", 32'(freeze), 32'd1);
            chk("halt_cause", 32'(halt_cause), 32'(exp_cause));
            if (widx < TOTAL) begin
               chk("word_valid", 32'(sif.out_valid), 32'd1);
               chk("word_kind", 32'(sif.out_kind), 32'(kind_of(widx)));
               chk("word_data", sif.out_data, exp_w[widx]);
               chk("word_done", 32'(dump_done), 32'd0);
               if (a5 && widx == 1 + NREG + 2) chk("mem2_a5", sif.out_data, 32'h0000_00A5);
               if (sif.out_valid && sif.out_ready) widx++;
            end else begin
               chk("done_valid", 32'(sif.out_valid), 32'd0);
               chk("done_flag", 32'(dump_done), 32'd1);
               tail++;
               if (tail == 3) fin = 1'b1;
            end
         end
         c++;
         if (!fin && c > exp_h + 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL case%0d timeout: got %0d words expected %0d", cur_case, widx, TOTAL);
            fin = 1'b1;
         end
      end
   endtask

   initial begin
      int za;
      int eh;
      bit ec;

      sif.out_ready = 1'b1;
      //            zero_at mode abort reset a5 exp_h cause
      tbl[0] = '{  5, 0,  -1, 1'b1, 1'b0,  5, 1'b0};
      tbl[1] = '{ -1, 0,  -1, 1'b1, 1'b0, 63, 1'b1};
      tbl[2] = '{ 63, 0,  -1, 1'b1, 1'b0, 63, 1'b0};
      tbl[3] = '{ 20, 1,  -1, 1'b1, 1'b0, 20, 1'b0};
      tbl[4] = '{ 10, 2,  -1, 1'b1, 1'b1, 10, 1'b0};
      tbl[5] = '{  3, 0,  11, 1'b1, 1'b0,  3, 1'b0};
      tbl[6] = '{  7, 0,  -1, 1'b0, 1'b0,  7, 1'b0};

      for (int t = 0; t < 7; t++) begin
         cur_case = t;
         run_case(tbl[t].zero_at, tbl[t].mode, tbl[t].abort_at, tbl[t].start_reset,
                  tbl[t].a5, tbl[t].exp_h, tbl[t].exp_cause);
      end

      // Randomized runs: halt cycle and cause come from the first-zero/budget rule.
      for (int r = 0; r < 4; r++) begin
         cur_case = 100 + r;
         za = $urandom_range(0, 80);
         if (za > 70) za = -1;
         eh = (za >= 0 && za < TMO - 1) ? za : TMO - 1;
         ec = !(za >= 0 && za <= TMO - 1);
         run_case(za, $urandom_range(0, 2), -1, 1'b1, 1'b0, eh, ec);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
